// File: rtl/ex_muldiv_iter_pkg.sv
// Shared types and helpers for the EX-stage iterative multiply/divide unit.
// Operation encoding, FSM states, signedness and leading-zero helpers.
package ex_muldiv_iter_pkg;

  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU,
    OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU, OP_ADD
  } Oper_t;

  typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} MulDivState_t;

  function automatic logic is_signed_md(Oper_t op);
    return op inside {OP_MULT, OP_MUL, OP_MADD, OP_MSUB, OP_DIV};
  endfunction

  function automatic logic is_mul_op(Oper_t op);
    return op inside {OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
  endfunction

  function automatic logic is_div_op(Oper_t op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  // Leading zeros of the low 'width' bits of v; returns width when all are zero.
  function automatic int clz(logic [63:0] v, int width);
    int c;
    c = width;
    for (int i = 0; i < 64; i++) begin
      if (i < width && v[i]) c = width - 1 - i;
    end
    return c;
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Unsigned restoring divider, one quotient bit per cycle after a load on go.
// done pulses one cycle after the last iteration; divisor 0 or zero iterations finish at once.
module div_iter_core #(
  parameter int WIDTH = 32,
  parameter int SKW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             go,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [SKW-1:0]   skip,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             done
);

  logic [WIDTH-1:0] dvs;
  logic [SKW-1:0]   cnt;
  logic             busy;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [SKW-1:0]   n_iter;

  assign trial  = {rem, quot[WIDTH-1]};
  assign diff   = trial - {1'b0, dvs};
  assign n_iter = SKW'(WIDTH) - skip;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      quot <= '0;
      rem  <= '0;
      done <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (go) begin
      dvs <= divisor;
      if (divisor == '0) begin
        quot <= '1;
        rem  <= dividend;
        cnt  <= '0;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        // Leading zeros are shifted out up front; the quotient ends up right-aligned.
        quot <= dividend << skip;
        rem  <= '0;
        cnt  <= n_iter;
        busy <= (n_iter != '0);
        done <= (n_iter == '0);
      end
    end else if (busy) begin
      if (!diff[WIDTH]) begin
        rem  <= diff[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], 1'b1};
      end else begin
        rem  <= trial[WIDTH-1:0];
        quot <= {quot[WIDTH-2:0], 1'b0};
      end
      cnt <= cnt - SKW'(1);
      if (cnt == SKW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_muldiv_iter.sv
// Multi-cycle EX multiply/divide: MUL_STAGES cycles for multiply, 2+iterations for divide.
// is_busy stalls EX from the start cycle until DONE; valid pulses once per result.
module ex_muldiv_iter
  import ex_muldiv_iter_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int MUL_STAGES    = 2,
  parameter bit DIV_EARLY_OUT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  Oper_t              op,
  input  logic [WIDTH-1:0]   reg1,
  input  logic [WIDTH-1:0]   reg2,
  input  logic [2*WIDTH-1:0] hilo,
  output logic [2*WIDTH-1:0] ret,
  output logic               valid,
  output logic               is_busy
);

  localparam int W2  = 2 * WIDTH;
  localparam int SKW = $clog2(WIDTH + 1);
  localparam int PS  = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;
  localparam int MCW = $clog2(MUL_STAGES + 1);

  MulDivState_t   state;
  Oper_t          op_q;
  logic           neg_q;
  logic           rneg_q;
  logic [W2-1:0]  hilo_q;
  logic [W2-1:0]  pipe [PS];
  logic [MCW-1:0] mul_cnt;

  logic             sgn, neg_in, rneg_in, div_go, div_done;
  logic [WIDTH-1:0] mag1, mag2, div_quot, div_rem;
  logic [W2-1:0]    prod0;
  logic [SKW-1:0]   skip;

  assign sgn     = is_signed_md(op);
  assign mag1    = (sgn && reg1[WIDTH-1]) ? -reg1 : reg1;
  assign mag2    = (sgn && reg2[WIDTH-1]) ? -reg2 : reg2;
  assign neg_in  = sgn && (reg1[WIDTH-1] ^ reg2[WIDTH-1]);
  assign rneg_in = sgn && reg1[WIDTH-1];
  assign prod0   = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
  assign skip    = DIV_EARLY_OUT ? SKW'(clz(64'(mag1), WIDTH)) : '0;
  assign div_go  = start && (state == MD_IDLE) && !flush && is_div_op(op);
  assign is_busy = (state == MD_MUL) || (state == MD_DIV) || (start && state == MD_IDLE);

  div_iter_core #(.WIDTH(WIDTH), .SKW(SKW)) u_div (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .go       (div_go),
    .dividend (mag1),
    .divisor  (mag2),
    .skip     (skip),
    .quot     (div_quot),
    .rem      (div_rem),
    .done     (div_done)
  );

  function automatic logic [W2-1:0] mul_result(Oper_t o, logic neg, logic [W2-1:0] p,
                                                logic [W2-1:0] hl);
    logic [W2-1:0] s;
    s = neg ? -p : p;
    if (o inside {OP_MADD, OP_MADDU}) return hl + s;
    if (o inside {OP_MSUB, OP_MSUBU}) return hl - s;
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MD_IDLE;
      ret     <= '0;
      valid   <= 1'b0;
      op_q    <= OP_NOP;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hilo_q  <= '0;
      mul_cnt <= '0;
      for (int k = 0; k < PS; k++) pipe[k] <= '0;
    end else begin
      valid <= 1'b0;
      if (state == MD_MUL) begin
        for (int k = 1; k < PS; k++) pipe[k] <= pipe[k-1];
      end
      if (flush) begin
        state <= MD_IDLE;
      end else begin
        case (state)
          MD_IDLE: if (start) begin
            op_q    <= op;
            neg_q   <= neg_in;
            rneg_q  <= rneg_in;
            hilo_q  <= hilo;
            pipe[0] <= prod0;
            mul_cnt <= MCW'(1);
            if (is_mul_op(op)) begin
              if (MUL_STAGES == 1) begin
                ret   <= mul_result(op, neg_in, prod0, hilo);
                valid <= 1'b1;
                state <= MD_DONE;
              end else begin
                state <= MD_MUL;
              end
            end else if (is_div_op(op)) begin
              state <= MD_DIV;
            end else begin
              ret   <= '0;
              valid <= 1'b1;
              state <= MD_DONE;
            end
          end
          MD_MUL: begin
            mul_cnt <= mul_cnt + 1'b1;
            if (mul_cnt == MCW'(MUL_STAGES - 1)) begin
              ret   <= mul_result(op_q, neg_q, pipe[PS-1], hilo_q);
              valid <= 1'b1;
              state <= MD_DONE;
            end
          end
          MD_DIV: if (div_done) begin
            // Sign fix: quotient takes the xor of operand signs, remainder the dividend sign.
            ret   <= {(rneg_q ? -div_rem : div_rem), (neg_q ? -div_quot : div_quot)};
            valid <= 1'b1;
            state <= MD_DONE;
          end
          MD_DONE: state <= MD_IDLE;
          default: state <= MD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Directed bench for ex_muldiv_iter: early-out and fixed-iteration divider instances side by side.
module tb_ex_muldiv_iter;
  import ex_muldiv_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  Oper_t       op = OP_NOP;
  logic [31:0] reg1 = '0;
  logic [31:0] reg2 = '0;
  logic [63:0] hilo = '0;
  logic [63:0] ret_e, ret_f;
  logic        valid_e, valid_f, busy_e, busy_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_muldiv_iter #(.WIDTH(32), .MUL_STAGES(2), .DIV_EARLY_OUT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .reg1(reg1), .reg2(reg2), .hilo(hilo),
    .ret(ret_e), .valid(valid_e), .is_busy(busy_e)
  );

  ex_muldiv_iter #(.WIDTH(32), .MUL_STAGES(2), .DIV_EARLY_OUT(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .reg1(reg1), .reg2(reg2), .hilo(hilo),
    .ret(ret_f), .valid(valid_f), .is_busy(busy_f)
  );

  typedef struct {
    Oper_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] h;
    logic [63:0] exp;
    int          lat_e;
    int          lat_f;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Launches one op, scrambles inputs afterwards, and waits for valid on both instances.
  task automatic run_op(input Oper_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, input string tag,
                        output int le, output int lf, output logic [63:0] re,
                        output logic [63:0] rf);
    le = -1; lf = -1; re = '0; rf = '0;
    @(posedge clk); #1;
    op = o; reg1 = a; reg2 = b; hilo = h; start = 1'b1;
    @(negedge clk);
    check({tag, " busy_in_start"}, 64'(busy_e), 64'd1);
    @(posedge clk); #1;
    start = 1'b0; op = OP_ADD; reg1 = $urandom; reg2 = $urandom; hilo = {$urandom, $urandom};
    for (int k = 1; k <= 80 && (le < 0 || lf < 0); k++) begin
      @(negedge clk);
      if (valid_e && le < 0) begin le = k; re = ret_e; end
      if (valid_f && lf < 0) begin lf = k; rf = ret_f; end
      if (le < 0 || lf < 0) @(posedge clk);
    end
    if (le < 0 || lf < 0) $display("FAIL %s timeout: valid_e_seen=%0d valid_f_seen=%0d", tag, le, lf);
  endtask

  initial begin
    int le, lf;
    logic [63:0] re, rf, prev;
    bit seen;

    vq.push_back('{OP_MULT,  32'hFFFFFFFE, 32'd3,        64'd0, 64'hFFFFFFFF_FFFFFFFA, 2, 2});
    vq.push_back('{OP_MSUBU, 32'd1,        32'd1,        64'd0, 64'hFFFFFFFF_FFFFFFFF, 2, 2});
    vq.push_back('{OP_DIV,   32'hFFFFFFF9, 32'd2,        64'd0, 64'hFFFFFFFF_FFFFFFFD, 5, 34});
    vq.push_back('{OP_DIVU,  32'h80000000, 32'd0,        64'd0, 64'h80000000_FFFFFFFF, 2, 2});
    vq.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd0, 64'hFFFFFFFE_00000001, 2, 2});
    vq.push_back('{OP_MUL,   32'd7,        32'hFFFFFFFD, 64'd0, 64'hFFFFFFFF_FFFFFFEB, 2, 2});
    vq.push_back('{OP_MADD,  32'hFFFFFFFE, 32'd5,        64'h10, 64'h6, 2, 2});
    vq.push_back('{OP_MADDU, 32'h10,       32'h10,       64'h00000001_00000000, 64'h00000001_00000100, 2, 2});
    vq.push_back('{OP_MSUB,  32'hFFFFFFFF, 32'd1,        64'd0, 64'h1, 2, 2});
    vq.push_back('{OP_DIVU,  32'd100,      32'd7,        64'd0, 64'h00000002_0000000E, 9, 34});
    vq.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'd0, 64'h00000000_80000000, 34, 34});
    vq.push_back('{OP_DIV,   32'd0,        32'd5,        64'd0, 64'h0, 2, 34});
    vq.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 64'd0, 64'h00000001_FFFFFFFD, 5, 34});
    vq.push_back('{OP_DIV,   32'hFFFFFFF8, 32'd0,        64'd0, 64'hFFFFFFF8_00000001, 2, 2});
    vq.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'd1,        64'd0, 64'h00000000_FFFFFFFF, 34, 34});
    vq.push_back('{OP_ADD,   32'd12,       32'd34,       64'd0, 64'h0, 1, 1});

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset ret_e", ret_e, 64'd0);
    check("reset valid_e", 64'(valid_e), 64'd0);
    check("reset busy_e", 64'(busy_e), 64'd0);
    check("reset ret_f", ret_f, 64'd0);

    foreach (vq[i]) begin
      string tag;
      tag = $sformatf("v%0d", i);
      run_op(vq[i].op, vq[i].a, vq[i].b, vq[i].h, tag, le, lf, re, rf);
      check({tag, " ret_e"}, re, vq[i].exp);
      check({tag, " ret_f"}, rf, vq[i].exp);
      check({tag, " lat_e"}, 64'(le), 64'(vq[i].lat_e));
      check({tag, " lat_f"}, 64'(lf), 64'(vq[i].lat_f));
      repeat (3) @(negedge clk);
      check({tag, " ret_hold"}, ret_e, vq[i].exp);
    end

    // Give ret a known non-zero value before the flush sequence.
    run_op(OP_MULTU, 32'd5, 32'd9, 64'd0, "pre_flush", le, lf, re, rf);
    check("pre_flush ret", re, 64'd45);
    prev = 64'd45;

    // Flush three cycles after a DIVU start: no valid, IDLE next cycle, ret untouched.
    seen = 1'b0;
    @(posedge clk); #1;
    op = OP_DIVU; reg1 = 32'd100; reg2 = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 flush = 1'b1;
    @(negedge clk);
    seen |= valid_e;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush busy_after", 64'(busy_e), 64'd0);
    check("flush ret_kept", ret_e, prev);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      seen |= valid_e;
    end
    check("flush no_valid", 64'(seen), 64'd0);
    check("flush ret_kept_late", ret_e, prev);
    run_op(OP_MULTU, 32'd6, 32'd7, 64'd0, "post_flush", le, lf, re, rf);
    check("post_flush ret", re, 64'd42);
    check("post_flush lat", 64'(le), 64'd2);

    // flush and start in the same cycle: start is dropped.
    seen = 1'b0;
    @(posedge clk); #1;
    op = OP_MULTU; reg1 = 32'd3; reg2 = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start busy", 64'(busy_e), 64'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      seen |= valid_e;
    end
    check("flush_start no_valid", 64'(seen), 64'd0);
    check("flush_start ret", ret_e, 64'd42);

    // Asynchronous reset in the middle of a long divide.
    seen = 1'b0;
    @(posedge clk); #1;
    op = OP_DIVU; reg1 = 32'hFFFFFFFF; reg2 = 32'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rst_mid busy_before", 64'(busy_e), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid busy", 64'(busy_e), 64'd0);
    check("rst_mid valid", 64'(valid_e), 64'd0);
    check("rst_mid ret", ret_e, 64'd0);
    check("rst_mid ret_f", ret_f, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen |= valid_e | valid_f;
    end
    check("rst_mid no_valid", 64'(seen), 64'd0);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 64'd0, "post_rst", le, lf, re, rf);
    check("post_rst ret", re, 64'hFFFFFFFF_FFFFFFFD);
    check("post_rst lat_e", 64'(le), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
